// File: rtl/bomberman_pkg.sv
// Shared definitions for the bomberman drawing subsystem.
// Holds the screen geometry, the requester index map used by the draw port
// arbiter, and the arbiter state encoding.
package bomberman_pkg;

    localparam int SCREEN_X_W = 8;  // 160-pixel wide screen
    localparam int SCREEN_Y_W = 7;  // 120-pixel tall screen
    localparam int COLOUR_W   = 3;

    // Requester slots on the shared VGA write port
    localparam int REQ_LOADER = 0;
    localparam int REQ_ERASE  = 1;
    localparam int REQ_DRAW   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting one slot after last, wrapping around, and returns the
// first asserted index.
//   req    : request vector
//   last   : index granted most recently
//   winner : selected index (0 when valid is low)
//   valid  : at least one request is asserted
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        // Walk from the farthest slot to the nearest so the nearest asserted
        // request (the round-robin winner) is the one that sticks.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_port_arbiter.sv
// Draw port arbiter: shares the single VGA adapter write port between the
// background loader, sprite eraser and sprite drawer.
// One requester is granted at a time in round-robin order and keeps the port
// until it signals done, drops its request, or the hold watchdog fires.
//   clock, resetn       : clock, asynchronous active-low reset
//   req, done           : per-requester request level and job-finished strobe
//   x_in, y_in,
//   colour_in, plot_in  : flattened per-requester pixel buses
//   grant               : registered one-hot grant
//   vga_x, vga_y,
//   vga_colour, vga_plot: muxed pixel bus of the granted requester (0 if none)
//   busy                : high in GRANT or RELEASE
//   draw_complete       : one-cycle pulse when a job ends through done
//   timeout             : sticky watchdog flag, cleared only by reset
//   state_dbg           : current FSM state
// Handshake: a requester holds req high for the whole job; its pixel strobes
// reach the adapter only while grant[i] is high; done[i] is taken in any
// cycle of the grant and ends the job, after which one RELEASE cycle
// separates it from the next grant.
module draw_port_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int X_W      = bomberman_pkg::SCREEN_X_W,
    parameter int Y_W      = bomberman_pkg::SCREEN_Y_W,
    parameter int COLOUR_W = bomberman_pkg::COLOUR_W,
    parameter int MAX_HOLD = 20000
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           done,
    input  logic [NUM_REQ*X_W-1:0]       x_in,
    input  logic [NUM_REQ*Y_W-1:0]       y_in,
    input  logic [NUM_REQ*COLOUR_W-1:0]  colour_in,
    input  logic [NUM_REQ-1:0]           plot_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot,
    output logic                         busy,
    output logic                         draw_complete,
    output logic                         timeout,
    output logic [1:0]                   state_dbg
);
    import bomberman_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    arb_state_t           state, state_nx;
    logic [IDX_W-1:0]     last_q, last_nx;
    logic [IDX_W-1:0]     gidx_q, gidx_nx;
    logic [CNT_W-1:0]     cnt_q, cnt_nx;
    logic [NUM_REQ-1:0]   grant_q, grant_nx;
    logic                 normal_q, normal_nx;  // current RELEASE came from done
    logic                 timeout_q, timeout_nx;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
            gidx_q    <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            normal_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nx;
            last_q    <= last_nx;
            gidx_q    <= gidx_nx;
            cnt_q     <= cnt_nx;
            grant_q   <= grant_nx;
            normal_q  <= normal_nx;
            timeout_q <= timeout_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        last_nx    = last_q;
        gidx_nx    = gidx_q;
        cnt_nx     = cnt_q;
        grant_nx   = grant_q;
        normal_nx  = normal_q;
        timeout_nx = timeout_q;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nx = ST_GRANT;
                    grant_nx = NUM_REQ'(1) << pick_idx;
                    last_nx  = pick_idx;
                    gidx_nx  = pick_idx;
                    cnt_nx   = '0;
                end
            end
            ST_GRANT: begin
                if (done[gidx_q]) begin
                    state_nx  = ST_RELEASE;
                    grant_nx  = '0;
                    normal_nx = 1'b1;
                end else if (!req[gidx_q]) begin
                    state_nx  = ST_RELEASE;
                    grant_nx  = '0;
                    normal_nx = 1'b0;
                end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    state_nx   = ST_RELEASE;
                    grant_nx   = '0;
                    normal_nx  = 1'b0;
                    timeout_nx = 1'b1;
                end else begin
                    // Only incremented while staying, so it never wraps.
                    cnt_nx = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_nx  = ST_IDLE;
                normal_nx = 1'b0;
            end
            default: begin
                state_nx  = ST_IDLE;
                grant_nx  = '0;
                normal_nx = 1'b0;
            end
        endcase
    end

    logic in_grant;
    assign in_grant = (state == ST_GRANT);

    assign grant         = grant_q;
    assign busy          = (state != ST_IDLE);
    assign draw_complete = (state == ST_RELEASE) && normal_q;
    assign timeout       = timeout_q;
    assign state_dbg     = state;

    assign vga_x      = in_grant ? x_in[int'(gidx_q) * X_W +: X_W] : '0;
    assign vga_y      = in_grant ? y_in[int'(gidx_q) * Y_W +: Y_W] : '0;
    assign vga_colour = in_grant ? colour_in[int'(gidx_q) * COLOUR_W +: COLOUR_W] : '0;
    assign vga_plot   = in_grant & plot_in[gidx_q];

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Testbench for draw_port_arbiter: directed scenarios followed by randomized
// engine behaviour, all outputs checked every cycle against a behavioural
// model through an expected-value queue.
module tb_draw_port_arbiter;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int MH = 16;
    localparam int VW = N + 3 + XW + YW + CW + 1;

    logic              clock;
    logic              resetn;
    logic [N-1:0]      req;
    logic [N-1:0]      done;
    logic [N*XW-1:0]   x_in;
    logic [N*YW-1:0]   y_in;
    logic [N*CW-1:0]   colour_in;
    logic [N-1:0]      plot_in;
    logic [N-1:0]      grant;
    logic [XW-1:0]     vga_x;
    logic [YW-1:0]     vga_y;
    logic [CW-1:0]     vga_colour;
    logic              vga_plot;
    logic              busy;
    logic              draw_complete;
    logic              timeout;
    logic [1:0]        state_dbg;

    draw_port_arbiter #(
        .NUM_REQ (N), .X_W (XW), .Y_W (YW), .COLOUR_W (CW), .MAX_HOLD (MH)
    ) dut (
        .clock (clock), .resetn (resetn), .req (req), .done (done),
        .x_in (x_in), .y_in (y_in), .colour_in (colour_in), .plot_in (plot_in),
        .grant (grant), .vga_x (vga_x), .vga_y (vga_y), .vga_colour (vga_colour),
        .vga_plot (vga_plot), .busy (busy), .draw_complete (draw_complete),
        .timeout (timeout), .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    logic [VW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Owner is the requester holding the port (-1 none); rel marks the single
    // gap cycle after a job, rel_norm whether that job ended via done.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_held  = 0;
    bit m_rel   = 0;
    bit m_norm  = 0;
    bit m_to    = 0;

    task automatic model_step();
        if (!resetn) begin
            m_owner = -1; m_last = N - 1; m_held = 0;
            m_rel = 0; m_norm = 0; m_to = 0;
        end else if (m_rel) begin
            m_rel = 0; m_norm = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            if (done[m_owner]) begin
                m_rel = 1; m_norm = 1; m_owner = -1;
            end else if (!req[m_owner]) begin
                m_rel = 1; m_norm = 0; m_owner = -1;
            end else if (m_held == MH) begin
                m_rel = 1; m_norm = 0; m_to = 1; m_owner = -1;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            m_last = m_owner;
            m_held = 0;
        end
    endtask

    function automatic logic [VW-1:0] model_out();
        logic [N-1:0]  g;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        logic          p;
        logic          b, dc, to;
        g = '0; x = '0; y = '0; c = '0; p = 1'b0; b = 1'b0; dc = 1'b0; to = 1'b0;
        if (resetn) begin
            if (m_owner >= 0) begin
                g = N'(1) << m_owner;
                x = x_in[m_owner*XW +: XW];
                y = y_in[m_owner*YW +: YW];
                c = colour_in[m_owner*CW +: CW];
                p = plot_in[m_owner];
            end
            b  = (m_owner >= 0) || m_rel;
            dc = m_rel && m_norm;
            to = m_to;
        end
        return {g, b, dc, to, x, y, c, p};
    endfunction

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        exp_q.push_back(model_out());
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        logic [VW-1:0] want;
        logic [VW-1:0] got;
        @(negedge clock);
        #1;
        got = {grant, busy, draw_complete, timeout, vga_x, vga_y, vga_colour, vga_plot};
        if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL outputs {grant,busy,dc,timeout,x,y,c,plot}: got %h, required %h at %0t",
                         got, want, $time);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = '0; done = '0; plot_in = '0;
        repeat (3) step();
        resetn = 1'b1;
    endtask

    task automatic wait_grant(output int g, output bit ok);
        ok = 0; g = -1;
        for (int t = 0; t < 12 && !ok; t++) begin
            step();
            if (grant != '0) begin
                ok = 1;
                for (int i = 0; i < N; i++) if (grant[i]) g = i;
            end
        end
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL wait_grant: no grant within 12 cycles at %0t", $time);
        end
    endtask

    task automatic pulse_done(input int i);
        done[i] = 1'b1;
        step();
        done = '0;
    endtask

    int eng_cnt[N];
    int eng_tgt[N];

    initial begin
        logic [N-1:0] seq_exp [4];
        int g;
        bit ok;
        resetn = 1'b0;
        req = '0; done = '0; plot_in = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        #1;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);

        // Basic grant, pixel mux and completion pulse
        do_reset();
        req = 3'b001; plot_in = 3'b001;
        x_in[0 +: XW] = 8'd10; y_in[0 +: YW] = 7'd20; colour_in[0 +: CW] = 3'd5;
        step();
        check("first_grant", 32'(grant), 32'b001);
        check("first_vga_x", 32'(vga_x), 32'd10);
        repeat (3) step();
        pulse_done(0);
        req = '0; plot_in = '0;
        repeat (3) step();

        // Fairness with all requesting, done 5 cycles after each grant
        do_reset();
        seq_exp[0] = 3'b001; seq_exp[1] = 3'b010; seq_exp[2] = 3'b100; seq_exp[3] = 3'b001;
        req = 3'b111;
        for (int j = 0; j < 4; j++) begin
            wait_grant(g, ok);
            if (ok) begin
                check("rr_sequence", 32'(grant), 32'(seq_exp[j]));
                repeat (4) step();
                pulse_done(g);
            end
        end
        req = '0;
        repeat (4) step();

        // Non-granted plot strobes are ignored
        req = 3'b010; plot_in = 3'b101; x_in[XW +: XW] = 8'd33; x_in[0 +: XW] = 8'd7;
        wait_grant(g, ok);
        check("masked_plot", 32'(vga_plot), 32'd0);
        check("masked_x", 32'(vga_x), 32'd33);
        repeat (2) step();
        pulse_done(1);
        req = '0; plot_in = '0;
        repeat (3) step();

        // Watchdog on requester 2
        req = 3'b100;
        repeat (MH + 4) step();
        check("timeout_sticky", 32'(timeout), 32'd1);
        req = 3'b000;
        repeat (2) step();
        req = 3'b001;
        wait_grant(g, ok);
        check("post_timeout_grant", 32'(grant), 32'b001);
        pulse_done(0);
        req = '0;
        repeat (3) step();

        // Abort: requester 1 drops without done, requester 2 pending
        req = 3'b110;
        wait_grant(g, ok);
        check("abort_first", 32'(grant), 32'b010);
        repeat (2) step();
        req = 3'b100;
        repeat (4) step();
        pulse_done(2);
        req = '0;
        repeat (3) step();

        // Asynchronous reset during a grant
        req = 3'b001; plot_in = 3'b001;
        wait_grant(g, ok);
        step();
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_plot",  32'(vga_plot), 32'd0);
        check("async_rst_busy",  32'(busy), 32'd0);
        req = 3'b110; plot_in = '0;
        repeat (2) step();
        resetn = 1'b1;
        step();
        check("post_reset_grant", 32'(grant), 32'b010);
        req = '0;
        repeat (3) step();

        // Randomized engines
        do_reset();
        for (int i = 0; i < N; i++) begin
            eng_cnt[i] = 0;
            eng_tgt[i] = $urandom_range(1, 8);
        end
        for (int t = 0; t < 3000; t++) begin
            step();
            done = '0;
            plot_in = N'($urandom);
            for (int i = 0; i < N; i++) begin
                x_in[i*XW +: XW]      = XW'($urandom);
                y_in[i*YW +: YW]      = YW'($urandom);
                colour_in[i*CW +: CW] = CW'($urandom);
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                    if ($urandom_range(0, 9) == 0) done[i] = 1'b1;
                end else if (grant[i]) begin
                    eng_cnt[i]++;
                    if (eng_cnt[i] >= eng_tgt[i]) begin
                        case ($urandom_range(0, 3))
                            0: req[i] = 1'b0;
                            1: begin done[i] = 1'b1; req[i] = 1'b0; end
                            default: done[i] = 1'b1;
                        endcase
                        eng_cnt[i] = 0;
                        eng_tgt[i] = ($urandom_range(0, 14) == 0) ? 20 : $urandom_range(1, 8);
                    end
                end else begin
                    eng_cnt[i] = 0;
                    if ($urandom_range(0, 9) == 0) done[i] = 1'b1;
                end
            end
        end
        req = '0; done = '0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
